// File: rtl/spi_master_shifter.sv
// rtl/spi_master_shifter.sv - SPI master shift engine driven by external clock generator strobes
module spi_master_shifter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_sclk,
    input  logic                  i_sclk_rise,
    input  logic                  i_sclk_fall,
    output logic                  o_clk_enable,
    input  logic                  i_start,
    input  logic                  i_cpol,
    input  logic                  i_cpha,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic                  i_miso,
    output logic                  o_sclk,
    output logic                  o_mosi,
    output logic                  o_cs_n,
    output logic                  o_busy,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_rx_valid
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, LEAD, XFER, DONE} state_t;

    state_t                state;
    logic                  cpol_q;
    logic                  cpha_q;
    logic [DATA_WIDTH-1:0] tx_sr;
    logic [DATA_WIDTH-1:0] rx_sr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_inc;

    assign count_inc = count + 1'b1;
    assign o_sclk    = i_sclk ^ cpol_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state        <= IDLE;
            cpol_q       <= 1'b0;
            cpha_q       <= 1'b0;
            tx_sr        <= '0;
            rx_sr        <= '0;
            count        <= '0;
            o_cs_n       <= 1'b1;
            o_clk_enable <= 1'b0;
            o_busy       <= 1'b0;
            o_mosi       <= 1'b0;
            o_rx_data    <= '0;
            o_rx_valid   <= 1'b0;
        end else begin
            o_rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        cpol_q <= i_cpol;
                        cpha_q <= i_cpha;
                        o_cs_n <= 1'b0;
                        o_busy <= 1'b1;
                        count  <= '0;
                        // cpha=0 presents the MSB before the first edge, so it leaves the shifter now
                        if (i_cpha) begin
                            tx_sr <= i_tx_data;
                        end else begin
                            tx_sr  <= {i_tx_data[DATA_WIDTH-2:0], 1'b0};
                            o_mosi <= i_tx_data[DATA_WIDTH-1];
                        end
                        state <= LEAD;
                    end
                end
                LEAD: begin
                    o_clk_enable <= 1'b1;
                    state        <= XFER;
                end
                XFER: begin
                    if (i_sclk_rise) begin
                        if (!cpha_q) begin
                            rx_sr <= {rx_sr[DATA_WIDTH-2:0], i_miso};
                            count <= count_inc;
                        end else begin
                            o_mosi <= tx_sr[DATA_WIDTH-1];
                            tx_sr  <= tx_sr << 1;
                        end
                    end else if (i_sclk_fall) begin
                        if (cpha_q) begin
                            rx_sr <= {rx_sr[DATA_WIDTH-2:0], i_miso};
                            count <= count_inc;
                        end else if (count < LAST) begin
                            o_mosi <= tx_sr[DATA_WIDTH-1];
                            tx_sr  <= tx_sr << 1;
                        end
                        if ((cpha_q ? count_inc : count) == LAST) begin
                            o_clk_enable <= 1'b0;
                            state        <= DONE;
                        end
                    end
                end
                DONE: begin
                    o_rx_data  <= rx_sr;
                    o_rx_valid <= 1'b1;
                    o_cs_n     <= 1'b1;
                    o_busy     <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
